// File: rtl/screen_scan_reader.sv
// Screen-region scan master: fetches frame-buffer words in address order and
// serialises each one LSB-first onto a ready/valid 1-bit pixel stream.
module screen_scan_reader #(
   parameter logic [14:0] BASE_ADDR     = 15'h4000,
   parameter int          WORDS_PER_ROW = 32,
   parameter int          ROWS          = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   output logic [14:0] mem_address,
   output logic        mem_rd,
   input  logic [15:0] mem_rdata,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic        pix_data,
   output logic        pix_sof,
   output logic        pix_eol,
   output logic        frame_done,
   output logic        busy
);

   localparam int FRAME_WORDS = WORDS_PER_ROW * ROWS;
   localparam int COL_W       = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
   localparam int ROW_W       = (ROWS > 1) ? $clog2(ROWS) : 1;

   localparam logic [12:0]      LAST_WORD = 13'(FRAME_WORDS - 1);
   localparam logic [COL_W-1:0] LAST_COL  = COL_W'(WORDS_PER_ROW - 1);
   localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(ROWS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      LOAD  = 2'd2,
      SHIFT = 2'd3
   } state_t;

   state_t           state_reg,      state_next;
   logic [12:0]      word_idx_reg,   word_idx_next;
   logic [COL_W-1:0] col_reg,        col_next;
   logic [ROW_W-1:0] row_reg,        row_next;
   logic [3:0]       bit_cnt_reg,    bit_cnt_next;
   logic [15:0]      shreg_reg,      shreg_next;
   logic [14:0]      addr_reg,       addr_next;
   logic             frame_done_reg, frame_done_next;

   logic accept;
   logic last_bit;
   logic last_word;

   assign accept    = (state_reg == SHIFT) && pix_ready;
   assign last_bit  = (bit_cnt_reg == 4'd15);
   assign last_word = (word_idx_reg == LAST_WORD);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= IDLE;
         word_idx_reg   <= '0;
         col_reg        <= '0;
         row_reg        <= '0;
         bit_cnt_reg    <= '0;
         shreg_reg      <= '0;
         addr_reg       <= BASE_ADDR;
         frame_done_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         word_idx_reg   <= word_idx_next;
         col_reg        <= col_next;
         row_reg        <= row_next;
         bit_cnt_reg    <= bit_cnt_next;
         shreg_reg      <= shreg_next;
         addr_reg       <= addr_next;
         frame_done_reg <= frame_done_next;
      end
   end

   // The address register is loaded on the edge that enters FETCH, so the
   // fetch address is already on the bus during the FETCH cycle itself.
   always_comb begin
      state_next      = state_reg;
      word_idx_next   = word_idx_reg;
      col_next        = col_reg;
      row_next        = row_reg;
      bit_cnt_next    = bit_cnt_reg;
      shreg_next      = shreg_reg;
      addr_next       = addr_reg;
      frame_done_next = 1'b0;

      case (state_reg)
         IDLE: begin
            if (enable) begin
               state_next    = FETCH;
               word_idx_next = '0;
               col_next      = '0;
               row_next      = '0;
               addr_next     = BASE_ADDR;
            end
         end

         FETCH: begin
            state_next = LOAD;
         end

         LOAD: begin
            shreg_next   = mem_rdata;
            bit_cnt_next = '0;
            state_next   = SHIFT;
         end

         SHIFT: begin
            if (accept) begin
               shreg_next   = {1'b0, shreg_reg[15:1]};
               bit_cnt_next = bit_cnt_reg + 4'd1;
               if (last_bit) begin
                  if (last_word) begin
                     frame_done_next = 1'b1;
                     word_idx_next   = '0;
                     col_next        = '0;
                     row_next        = '0;
                     addr_next       = BASE_ADDR;
                     // enable is only looked at here and in IDLE: a frame
                     // in progress always runs to completion.
                     state_next      = enable ? FETCH : IDLE;
                  end else begin
                     word_idx_next = word_idx_reg + 13'd1;
                     addr_next     = BASE_ADDR + 15'(word_idx_reg + 13'd1);
                     if (col_reg == LAST_COL) begin
                        col_next = '0;
                        row_next = (row_reg == LAST_ROW) ? '0 : row_reg + ROW_W'(1);
                     end else begin
                        col_next = col_reg + COL_W'(1);
                     end
                     state_next = FETCH;
                  end
               end
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign mem_address = addr_reg;
   assign mem_rd      = (state_reg == FETCH);
   assign pix_valid   = (state_reg == SHIFT);
   assign pix_data    = pix_valid && shreg_reg[0];
   assign pix_sof     = pix_valid && (word_idx_reg == 13'd0) && (bit_cnt_reg == 4'd0);
   assign pix_eol     = pix_valid && (col_reg == LAST_COL) && last_bit;
   assign frame_done  = frame_done_reg;
   assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_screen_scan_reader.sv
// Directed bench for screen_scan_reader on a reduced 4x4-word frame so that
// several complete frames fit in a short run.
module tb_screen_scan_reader;

   localparam int WPR    = 4;
   localparam int NROWS  = 4;
   localparam int NWORDS = WPR * NROWS;
   localparam int PPF    = NWORDS * 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [14:0] mem_address;
   logic        mem_rd;
   logic [15:0] mem_rdata;
   logic        pix_valid;
   logic        pix_ready;
   logic        pix_data;
   logic        pix_sof;
   logic        pix_eol;
   logic        frame_done;
   logic        busy;

   screen_scan_reader #(
      .BASE_ADDR    (15'h4000),
      .WORDS_PER_ROW(WPR),
      .ROWS         (NROWS)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .mem_address(mem_address),
      .mem_rd     (mem_rd),
      .mem_rdata  (mem_rdata),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .pix_data   (pix_data),
      .pix_sof    (pix_sof),
      .pix_eol    (pix_eol),
      .frame_done (frame_done),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Memory model: read data follows the address by one clock.
   logic [15:0] mem [0:NWORDS-1];
   logic [15:0] rd_q = 16'h0;
   logic        prev_rd = 1'b0;
   logic        force_mode = 1'b0;

   always @(posedge clk) begin
      rd_q    <= mem[mem_address[3:0]];
      prev_rd <= mem_rd;
   end
   assign mem_rdata = force_mode ? (prev_rd ? 16'h0000 : 16'hFFFF) : rd_q;

   // Ready generator: 0 = always 1, 1 = repeating 1,0,0,1, 2 = random.
   int ready_mode = 0;
   int ready_ph   = 0;
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0: pix_ready = 1'b1;
            1: begin
               pix_ready = (ready_ph == 0) || (ready_ph == 3);
               ready_ph  = (ready_ph + 1) % 4;
            end
            default: pix_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Stream monitor
   logic        acc_pix [$];
   int          sof_idx [$];
   int          eol_idx [$];
   int          sof_cyc [$];
   int          fd_cyc  [$];
   logic [14:0] addr_q  [$];
   int          last_acc_cyc;
   int          stall_viol, rd_viol, flag_viol, fd_rd_cnt;
   logic        prev_stall, prev_data, prev_sof, prev_eol, prev_valid, prev_mrd;

   task automatic clear_mon();
      acc_pix.delete();
      sof_idx.delete();
      eol_idx.delete();
      sof_cyc.delete();
      fd_cyc.delete();
      addr_q.delete();
      last_acc_cyc = -1;
      stall_viol   = 0;
      rd_viol      = 0;
      flag_viol    = 0;
      fd_rd_cnt    = 0;
   endtask

   initial begin
      prev_stall = 0; prev_data = 0; prev_sof = 0; prev_eol = 0;
      prev_valid = 0; prev_mrd = 0;
      clear_mon();
      forever begin
         @(negedge clk);
         if (pix_valid && pix_ready) begin
            acc_pix.push_back(pix_data);
            if (pix_sof) sof_idx.push_back(acc_pix.size() - 1);
            if (pix_eol) eol_idx.push_back(acc_pix.size() - 1);
            last_acc_cyc = cyc;
         end
         if (!pix_valid && (pix_sof || pix_eol || pix_data)) flag_viol++;
         if (pix_valid && pix_sof && !(prev_valid && prev_sof)) sof_cyc.push_back(cyc);
         if (frame_done) begin
            fd_cyc.push_back(cyc);
            if (mem_rd) fd_rd_cnt++;
         end
         if (mem_rd) begin
            addr_q.push_back(mem_address);
            if (prev_mrd) rd_viol++;
         end
         if (prev_stall && (!pix_valid || pix_data != prev_data ||
                            pix_sof != prev_sof || pix_eol != prev_eol))
            stall_viol++;
         prev_stall = pix_valid && !pix_ready;
         prev_data  = pix_data;
         prev_sof   = pix_sof;
         prev_eol   = pix_eol;
         prev_valid = pix_valid;
         prev_mrd   = mem_rd;
      end
   end

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_reset_outs(input string name);
      check(name, {17'd0, mem_address, mem_rd, pix_valid, pix_data, pix_sof,
                   pix_eol, frame_done, busy},
            {17'd0, 15'h4000, 7'b0});
   endtask

   task automatic wait_idle(input int max, input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < max);
      check(name, {31'd0, busy}, 32'd0);
   endtask

   // Enable pulse of one clock, with the FETCH/LOAD/SHIFT latency checked.
   task automatic start_frame(input logic first_pix);
      @(posedge clk);
      #1 enable = 1'b1;
      @(posedge clk);
      #1 enable = 1'b0;
      @(negedge clk);
      check("fetch_rd",   {31'd0, mem_rd}, 32'd1);
      check("fetch_addr", {17'd0, mem_address}, 32'h4000);
      @(negedge clk);
      check("load_cycle", {30'd0, mem_rd, pix_valid}, 32'd0);
      @(negedge clk);
      check("first_pix", {29'd0, pix_valid, pix_sof, pix_data}, {29'd0, 2'b11, first_pix});
   endtask

   function automatic int frame_mismatches();
      int errs = 0;
      for (int i = 0; i < acc_pix.size(); i++)
         if (acc_pix[i] !== mem[(i / 16) % NWORDS][i % 16]) errs++;
      return errs;
   endfunction

   function automatic int addr_errors(input int nframes);
      int errs = 0;
      for (int i = 0; i < addr_q.size(); i++)
         if (addr_q[i] !== 15'(15'h4000 + (i % NWORDS))) errs++;
      if (addr_q.size() != nframes * NWORDS) errs++;
      return errs;
   endfunction

   typedef struct {
      logic [15:0] word;
      string       exp_seq;
      int          mode;
   } vec_t;

   vec_t vecs[5];

   initial begin
      logic [15:0] got, exp;
      int          errs, ones;

      vecs[0] = '{16'h0005, "1010000000000000", 0};
      vecs[1] = '{16'hA5A5, "1010010110100101", 1};
      vecs[2] = '{16'h8001, "1000000000000001", 2};
      vecs[3] = '{16'h00FF, "1111111100000000", 1};
      vecs[4] = '{16'h1234, "0010110001001000", 0};

      reset = 1'b1;
      enable = 1'b0;
      pix_ready = 1'b0;
      for (int i = 0; i < NWORDS; i++) mem[i] = 16'h0;

      repeat (3) @(negedge clk);
      check_reset_outs("reset_state");
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outs("idle_after_reset");

      // Single frames, word 0 from the table, remaining words random.
      for (int v = 0; v < 5; v++) begin
         mem[0] = vecs[v].word;
         for (int i = 1; i < NWORDS; i++) mem[i] = 16'($urandom);
         ready_mode = vecs[v].mode;
         clear_mon();
         start_frame(vecs[v].exp_seq[0] == 8'h31);
         wait_idle(5000, "frame_end_idle");

         exp = '0;
         got = '0;
         for (int i = 0; i < 16; i++) begin
            byte b;
            b = vecs[v].exp_seq[i];
            exp[i] = (b == 8'h31);
            if (i < acc_pix.size()) got[i] = acc_pix[i];
         end
         check("pix_seq", {16'd0, got}, {16'd0, exp});
         check("accept_count", acc_pix.size(), PPF);
         check("frame_pixels", frame_mismatches(), 0);
         check("sof_count", sof_idx.size(), 1);
         check("sof_pos", (sof_idx.size() > 0) ? sof_idx[0] : -1, 0);
         errs = 0;
         for (int k = 0; k < eol_idx.size(); k++)
            if (eol_idx[k] != 64 * k + 63) errs++;
         check("eol_count", eol_idx.size(), NROWS);
         check("eol_pos", errs, 0);
         check("frame_done_count", fd_cyc.size(), 1);
         check("frame_done_delay", (fd_cyc.size() > 0) ? fd_cyc[0] - last_acc_cyc : -1, 1);
         check("addr_order", addr_errors(1), 0);
         check("mem_rd_single", rd_viol, 0);
         check("stall_stable", stall_viol, 0);
         check("flags_no_valid", flag_viol, 0);
         $display("[TB] vec %0d word=%h ready_mode=%0d pixels=%0d first16=%b", v,
                  vecs[v].word, vecs[v].mode, acc_pix.size(), got);
      end

      // enable held high: two frames back to back, then drop mid-frame.
      begin
         int n;
         ready_mode = 0;
         clear_mon();
         @(posedge clk);
         #1 enable = 1'b1;
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (fd_cyc.size() < 1 && n < 2000);
         check("b2b_first_done", fd_cyc.size(), 1);
         repeat (10) @(negedge clk);
         enable = 1'b0;
         wait_idle(2000, "b2b_idle");
         check("b2b_done_count", fd_cyc.size(), 2);
         check("b2b_sof_count", sof_cyc.size(), 2);
         check("b2b_done_to_sof",
               (sof_cyc.size() > 1 && fd_cyc.size() > 0) ? sof_cyc[1] - fd_cyc[0] : -1, 2);
         check("b2b_done_in_fetch", fd_rd_cnt, 1);
         check("b2b_addr_order", addr_errors(2), 0);
         check("b2b_accepts", acc_pix.size(), 2 * PPF);
         check("b2b_pixels", frame_mismatches(), 0);
         $display("[TB] back-to-back frames: done=%0d accepts=%0d", fd_cyc.size(), acc_pix.size());
      end

      // Read data is all ones except during LOAD, where it is zero.
      for (int i = 0; i < NWORDS; i++) mem[i] = 16'hFFFF;
      force_mode = 1'b1;
      ready_mode = 2;
      clear_mon();
      start_frame(1'b0);
      wait_idle(5000, "force_idle");
      ones = 0;
      foreach (acc_pix[i]) if (acc_pix[i]) ones++;
      check("force_accepts", acc_pix.size(), PPF);
      check("force_all_zero", ones, 0);
      force_mode = 1'b0;
      $display("[TB] load-only capture: accepts=%0d ones=%0d", acc_pix.size(), ones);

      // Reset in the middle of SHIFT, then a clean restart.
      begin
         int n;
         for (int i = 0; i < NWORDS; i++) mem[i] = 16'($urandom);
         ready_mode = 0;
         clear_mon();
         start_frame(mem[0][0]);
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!(addr_q.size() >= 4 && pix_valid) && n < 500);
         check("midshift_reached", {30'd0, pix_valid, mem_address == 15'h4003}, 32'd3);
         #1 reset = 1'b1;
         #1 check_reset_outs("reset_mid_shift");
         @(negedge clk);
         check_reset_outs("reset_held");
         reset = 1'b0;
         @(negedge clk);
         clear_mon();
         start_frame(mem[0][0]);
         wait_idle(2000, "restart_idle");
         check("restart_first_addr", (addr_q.size() > 0) ? {17'd0, addr_q[0]} : 32'd0, 32'h4000);
         check("restart_accepts", acc_pix.size(), PPF);
         check("restart_pixels", frame_mismatches(), 0);
         check("restart_sof_pos", (sof_idx.size() > 0) ? sof_idx[0] : -1, 0);
         $display("[TB] reset mid-frame and restart: accepts=%0d", acc_pix.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
